apb_textmode_writer: RTL and testbench

- APB3 slave that turns CPU register writes into write strobes for the 80x60 text-mode character buffer (char/addr/wen write port of the VGA text-mode top).
- Keeps a hardware cursor: each DATA write stores one character at the cursor, then advances it.
- Handles CR/LF control codes.
- Provides a hardware clear-screen sweep that stalls the bus while it runs.

---
 rtl/apb_textmode_pkg.sv | 23 ++
 rtl/textmode_cursor.sv | 67 ++++++
 rtl/apb_textmode_writer.sv | 158 +++++++++++++++
 tb/tb_apb_textmode_writer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_textmode_pkg.sv
// Shared definitions for the APB text-mode writer: register map, control codes,
// FSM states and default screen geometry.
package apb_textmode_pkg;

    localparam int unsigned DEF_COLS = 80;
    localparam int unsigned DEF_ROWS = 60;

    // Byte offsets of the register map
    localparam logic [3:0] DATA_OFF   = 4'h0;
    localparam logic [3:0] CURSOR_OFF = 4'h4;
    localparam logic [3:0] CTRL_OFF   = 4'h8;
    localparam logic [3:0] STATUS_OFF = 4'hC;

    // Control codes that move the cursor instead of printing
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

endpackage

// File: rtl/textmode_cursor.sv
// Hardware cursor for the text buffer: linear cell index with advance,
// carriage return, line feed, load and clear. Wraps at the end of the screen.
module textmode_cursor
    import apb_textmode_pkg::*;
#(
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned CELL_W = $clog2(COLS * ROWS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              advance_i,
    input  logic              cr_i,
    input  logic              lf_i,
    input  logic              load_i,
    input  logic [CELL_W-1:0] load_val_i,
    input  logic              clear_i,
    output logic [CELL_W-1:0] idx_o
);

    localparam logic [CELL_W-1:0] COLS_W      = CELL_W'(COLS);
    localparam logic [CELL_W-1:0] LAST_CELL   = CELL_W'(COLS * ROWS - 1);
    localparam logic [CELL_W-1:0] LAST_ROW_ST = CELL_W'((ROWS - 1) * COLS);

    logic [CELL_W-1:0] idx_q;
    logic [CELL_W-1:0] idx_d;
    logic [CELL_W-1:0] row_start;
    logic [CELL_W-1:0] next_row;

    // Row arithmetic; the last row is caught before the add so the sum stays on screen
    always_comb begin
        row_start = idx_q - (idx_q % COLS_W);
        if (row_start >= LAST_ROW_ST) begin
            next_row = '0;
        end else begin
            next_row = row_start + COLS_W;
        end
    end

    // Next-state selection; clear from the sweep has the highest priority
    always_comb begin
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (load_i) begin
            idx_d = load_val_i;
        end else if (lf_i) begin
            idx_d = next_row;
        end else if (cr_i) begin
            idx_d = row_start;
        end else if (advance_i) begin
            idx_d = (idx_q == LAST_CELL) ? '0 : idx_q + CELL_W'(1);
        end
    end

    // Cursor register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/apb_textmode_writer.sv
// APB3 slave converting register writes into write strobes for the text-mode
// character buffer. Supports a cursor, CR/LF handling and a clear-screen sweep
// that stalls the bus (STATUS stays readable).
// Build option: define APB_TEXTMODE_AUTOCLEAR_EN to start with a clear sweep
// right after reset is released.
module apb_textmode_writer
    import apb_textmode_pkg::*;
#(
    parameter int unsigned COLS      = DEF_COLS,
    parameter int unsigned ROWS      = DEF_ROWS,
    parameter logic [7:0]  FILL_CHAR = 8'h20,
    parameter int unsigned CELL_W    = $clog2(COLS * ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [3:0]        paddr_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic [7:0]        char_o,
    output logic [CELL_W-1:0] addr_o,
    output logic              wen_o
);

    localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(COLS * ROWS - 1);
    localparam logic [31:0]       NUM_CELLS = 32'(COLS * ROWS);

`ifdef APB_TEXTMODE_AUTOCLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t            state_q;
    logic              wen_q;
    logic [7:0]        char_q;
    logic [CELL_W-1:0] addr_q;

    logic              busy;
    logic              access;
    logic              stall;
    logic              err;
    logic              done;
    logic              data_wr;
    logic              cursor_wr;
    logic              ctrl_start;
    logic [7:0]        code;
    logic              is_cr;
    logic              is_lf;
    logic              printable;
    logic              sweep_last;
    logic [CELL_W-1:0] cursor_idx;

    // A pending strobe counts as busy so a new write never overlaps it
    assign busy   = (state_q == CLEAR) | wen_q;
    assign access = psel_i & penable_i;
    assign stall  = busy & (paddr_i != STATUS_OFF);

    assign pready_o  = access & ~stall;
    assign pslverr_o = pready_o & err;
    assign done      = pready_o & ~err;

    // Illegal accesses complete with an error and no side effect
    always_comb begin
        err = 1'b0;
        if (paddr_i[1:0] != 2'b00) begin
            err = 1'b1;
        end else if (pwrite_i && (paddr_i == STATUS_OFF)) begin
            err = 1'b1;
        end else if (pwrite_i && (paddr_i == CURSOR_OFF) && (pwdata_i >= NUM_CELLS)) begin
            err = 1'b1;
        end
    end

    assign code       = pwdata_i[7:0];
    assign is_cr      = (code == CHAR_CR);
    assign is_lf      = (code == CHAR_LF);
    assign printable  = ~is_cr & ~is_lf;
    assign data_wr    = done & pwrite_i & (paddr_i == DATA_OFF);
    assign cursor_wr  = done & pwrite_i & (paddr_i == CURSOR_OFF);
    assign ctrl_start = done & pwrite_i & (paddr_i == CTRL_OFF) & pwdata_i[0];
    assign sweep_last = (state_q == CLEAR) & wen_q & (addr_q == LAST_CELL);

    // Read mux; only CURSOR and STATUS return data
    always_comb begin
        prdata_o = '0;
        if (done && !pwrite_i) begin
            case (paddr_i)
                CURSOR_OFF: prdata_o = 32'(cursor_idx);
                STATUS_OFF: prdata_o = {31'b0, busy};
                default:    prdata_o = '0;
            endcase
        end
    end

    textmode_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .CELL_W (CELL_W)
    ) u_cursor (
        .clk_i      (clk),
        .rst_ni     (rst),
        .advance_i  (data_wr & printable),
        .cr_i       (data_wr & is_cr),
        .lf_i       (data_wr & is_lf),
        .load_i     (cursor_wr),
        .load_val_i (pwdata_i[CELL_W-1:0]),
        .clear_i    (sweep_last),
        .idx_o      (cursor_idx)
    );

    // FSM with registered buffer write port; the sweep reuses addr_q as its counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RESET_STATE;
            wen_q   <= 1'b0;
            char_q  <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wen_q <= 1'b0;
                    if (data_wr && printable) begin
                        wen_q  <= 1'b1;
                        char_q <= code;
                        addr_q <= cursor_idx;
                    end else if (ctrl_start) begin
                        state_q <= CLEAR;
                        wen_q   <= 1'b1;
                        char_q  <= FILL_CHAR;
                        addr_q  <= '0;
                    end
                end
                CLEAR: begin
                    if (sweep_last) begin
                        state_q <= IDLE;
                        wen_q   <= 1'b0;
                    end else begin
                        // First sweep cycle after an auto-start has no strobe yet
                        wen_q  <= 1'b1;
                        char_q <= FILL_CHAR;
                        addr_q <= wen_q ? addr_q + CELL_W'(1) : '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wen_o  = wen_q;
    assign char_o = char_q;
    assign addr_o = addr_q;

endmodule

// File: tb/tb_apb_textmode_writer.sv
module tb_apb_textmode_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int CELLS = COLS * ROWS;
    localparam int LIMIT = 6000;

    localparam logic [3:0] A_DATA   = 4'h0;
    localparam logic [3:0] A_CURSOR = 4'h4;
    localparam logic [3:0] A_CTRL   = 4'h8;
    localparam logic [3:0] A_STATUS = 4'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;
    logic [7:0]  char_o;
    logic [12:0] addr_o;
    logic        wen_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    apb_textmode_writer dut (
        .clk       (clk),
        .rst       (rst),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata_o),
        .pready_o  (pready_o),
        .pslverr_o (pslverr_o),
        .char_o    (char_o),
        .addr_o    (addr_o),
        .wen_o     (wen_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the completing edge.
    task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err, output int waits);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        waits = 0;
        while (pready_o !== 1'b1 && waits < LIMIT) begin
            @(posedge clk); #2;
            waits++;
        end
        chk("pready_bound", 32'(waits < LIMIT), 32'd1);
        rd  = prdata_o;
        err = pslverr_o;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Expected write strobe packed as {wen, char, addr}
    function automatic logic [31:0] strobe(input logic w, input logic [7:0] c, input int a);
        return {10'b0, w, c, 13'(a)};
    endfunction

    task automatic autoclear_check(input string tag);
        int c_rel, w;
        logic [31:0] rd;
        logic e;
        c_rel = cyc;
        apb(1'b0, A_STATUS, 32'd0, rd, e, w);
        chk({tag, "_busy"}, rd, 32'd1);
        chk({tag, "_status_wait"}, 32'(w), 32'd0);
        while (wen_o === 1'b1 && (cyc - c_rel) < LIMIT) begin
            @(posedge clk); #1;
        end
        chk({tag, "_len"}, 32'(cyc - c_rel), 32'(CELLS + 1));
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          w, c0, cur, op, v;
        logic [7:0]  ch;

        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_prdata", prdata_o, 32'd0);
        chk("rst_pready", 32'(pready_o), 32'd0);
        chk("rst_pslverr", 32'(pslverr_o), 32'd0);
        chk("rst_strobe", strobe(wen_o, char_o, int'(addr_o)), strobe(1'b0, 8'h00, 0));
        rst = 1'b1;
`ifdef APB_TEXTMODE_AUTOCLEAR_EN
        autoclear_check("autoclear");
`endif

        // Single printable write at cursor 0
        apb(1'b1, A_DATA, 32'h41, rd, e, w);
        chk("data41_err", 32'(e), 32'd0);
        chk("data41_strobe", strobe(wen_o, char_o, int'(addr_o)), strobe(1'b1, 8'h41, 0));
        @(posedge clk); #1;
        chk("data41_one_cycle", 32'(wen_o), 32'd0);
        apb(1'b0, A_CURSOR, 32'd0, rd, e, w);
        chk("cursor_after_41", rd, 32'd1);

        // Wrap at the last cell
        apb(1'b1, A_CURSOR, 32'd4799, rd, e, w);
        apb(1'b1, A_DATA, 32'h42, rd, e, w);
        chk("data42_strobe", strobe(wen_o, char_o, int'(addr_o)), strobe(1'b1, 8'h42, 4799));
        apb(1'b0, A_CURSOR, 32'd0, rd, e, w);
        chk("cursor_wrap", rd, 32'd0);

        // CR / LF
        apb(1'b1, A_CURSOR, 32'd165, rd, e, w);
        apb(1'b1, A_DATA, 32'h0D, rd, e, w);
        chk("cr_no_wen", 32'(wen_o), 32'd0);
        apb(1'b0, A_CURSOR, 32'd0, rd, e, w);
        chk("cr_cursor", rd, 32'd160);
        apb(1'b1, A_DATA, 32'h0A, rd, e, w);
        chk("lf_no_wen", 32'(wen_o), 32'd0);
        apb(1'b0, A_CURSOR, 32'd0, rd, e, w);
        chk("lf_cursor", rd, 32'd240);
        apb(1'b1, A_CURSOR, 32'd4750, rd, e, w);
        apb(1'b1, A_DATA, 32'h0A, rd, e, w);
        apb(1'b0, A_CURSOR, 32'd0, rd, e, w);
        chk("lf_last_row", rd, 32'd0);

        // Back-to-back writes land two cycles apart
        apb(1'b1, A_DATA, 32'h61, rd, e, w);
        c0 = cyc;
        chk("b2b_first", strobe(wen_o, char_o, int'(addr_o)), strobe(1'b1, 8'h61, 0));
        apb(1'b1, A_DATA, 32'h62, rd, e, w);
        chk("b2b_spacing", 32'(cyc - c0), 32'd2);
        chk("b2b_second", strobe(wen_o, char_o, int'(addr_o)), strobe(1'b1, 8'h62, 1));

        // Error responses
        apb(1'b1, A_CURSOR, 32'd4800, rd, e, w);
        chk("cursor_4800_err", 32'(e), 32'd1);
        apb(1'b1, A_CURSOR, 32'h0001_0000, rd, e, w);
        chk("cursor_high_err", 32'(e), 32'd1);
        apb(1'b0, A_CURSOR, 32'd0, rd, e, w);
        chk("cursor_unchanged", rd, 32'd2);
        apb(1'b0, 4'h2, 32'd0, rd, e, w);
        chk("misaligned_err", 32'(e), 32'd1);
        apb(1'b1, A_STATUS, 32'd1, rd, e, w);
        chk("status_wr_err", 32'(e), 32'd1);
        apb(1'b0, A_DATA, 32'd0, rd, e, w);
        chk("data_read_zero", {rd[30:0], e}, 32'd0);
        apb(1'b0, A_CTRL, 32'd0, rd, e, w);
        chk("ctrl_read_zero", {rd[30:0], e}, 32'd0);
        apb(1'b1, A_CTRL, 32'd0, rd, e, w);
        chk("ctrl0_no_wen", 32'(wen_o), 32'd0);
        apb(1'b0, A_STATUS, 32'd0, rd, e, w);
        chk("ctrl0_idle", rd, 32'd0);

        // Full clear sweep, cell by cell
        apb(1'b1, A_CTRL, 32'd1, rd, e, w);
        chk("ctrl1_err", 32'(e), 32'd0);
        for (int i = 0; i < CELLS; i++) begin
            chk("sweep_cell", strobe(wen_o, char_o, int'(addr_o)), strobe(1'b1, 8'h20, i));
            @(posedge clk); #1;
        end
        chk("sweep_end", 32'(wen_o), 32'd0);

        // Status during sweep, DATA write stalled until the end
        apb(1'b1, A_CTRL, 32'd1, rd, e, w);
        c0 = cyc;
        apb(1'b0, A_STATUS, 32'd0, rd, e, w);
        chk("sweep_busy", rd, 32'd1);
        chk("sweep_status_wait", 32'(w), 32'd0);
        apb(1'b1, A_DATA, 32'h58, rd, e, w);
        chk("stalled_done_cycle", 32'(cyc - c0), 32'(CELLS + 1));
        chk("stalled_strobe", strobe(wen_o, char_o, int'(addr_o)), strobe(1'b1, 8'h58, 0));

        // Randomized traffic against an arithmetic cursor model
        cur = 1;
        for (int n = 0; n < 120; n++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 4) begin
                ch = 8'($urandom_range(0, 255));
                if (ch == 8'h0A || ch == 8'h0D) ch = 8'h7E;
                apb(1'b1, A_DATA, 32'(ch), rd, e, w);
                chk("rnd_data", strobe(wen_o, char_o, int'(addr_o)), strobe(1'b1, ch, cur));
                cur = (cur + 1) % CELLS;
            end else if (op == 5) begin
                apb(1'b1, A_DATA, 32'h0D, rd, e, w);
                chk("rnd_cr_wen", 32'(wen_o), 32'd0);
                cur = (cur / COLS) * COLS;
            end else if (op == 6) begin
                apb(1'b1, A_DATA, 32'h0A, rd, e, w);
                chk("rnd_lf_wen", 32'(wen_o), 32'd0);
                cur = ((cur / COLS + 1) % ROWS) * COLS;
            end else if (op == 7) begin
                case ($urandom_range(0, 3))
                    0: v = CELLS - 1;
                    1: v = (ROWS - 1) * COLS + int'($urandom_range(0, COLS - 1));
                    default: v = int'($urandom_range(0, CELLS - 1));
                endcase
                apb(1'b1, A_CURSOR, 32'(v), rd, e, w);
                chk("rnd_load_err", 32'(e), 32'd0);
                cur = v;
            end else if (op == 8) begin
                apb(1'b1, A_CURSOR, 32'($urandom_range(CELLS, 32'h00FF_FFFF)), rd, e, w);
                chk("rnd_badload_err", 32'(e), 32'd1);
            end else begin
                apb(1'b0, A_CURSOR, 32'd0, rd, e, w);
                chk("rnd_cursor", rd, 32'(cur));
            end
        end
        apb(1'b0, A_CURSOR, 32'd0, rd, e, w);
        chk("rnd_final_cursor", rd, 32'(cur));

        // Reset in the middle of a sweep
        apb(1'b1, A_CTRL, 32'd1, rd, e, w);
        repeat (1000) @(posedge clk);
        #1;
        chk("pre_reset_addr", 32'(addr_o), 32'd1000);
        rst = 1'b0;
        #1;
        chk("mid_reset_strobe", strobe(wen_o, char_o, int'(addr_o)), strobe(1'b0, 8'h00, 0));
        @(posedge clk); #1;
        rst = 1'b1;
`ifdef APB_TEXTMODE_AUTOCLEAR_EN
        autoclear_check("rst_autoclear");
`else
        chk("post_reset_wen", 32'(wen_o), 32'd0);
        apb(1'b0, A_STATUS, 32'd0, rd, e, w);
        chk("post_reset_busy", rd, 32'd0);
        chk("post_reset_no_wen", 32'(wen_o), 32'd0);
`endif
        apb(1'b0, A_CURSOR, 32'd0, rd, e, w);
        chk("post_reset_cursor", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
